// File: rtl/marker_centroid_multi.sv
// marker_centroid_multi: per-channel colour-masked marker centroids.
// Frame sums feed one shared restoring divider after each frame end.
module marker_centroid_multi #(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int PIX_W   = 12,
  parameter int N_CH    = 2,
  parameter int MIN_PIX = 4,
  localparam int XW     = $clog2(IMG_W),
  localparam int YW     = $clog2(IMG_H),
  localparam int CW     = $clog2(IMG_W * IMG_H + 1),
  localparam int DIV_W  = ((XW > YW) ? XW : YW) + CW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync,
  input  logic                  pix_valid,
  input  logic [PIX_W-1:0]      pixel,
  input  logic [N_CH*PIX_W-1:0] match_val,
  input  logic [N_CH*PIX_W-1:0] match_mask,
  output logic [N_CH*XW-1:0]    cx,
  output logic [N_CH*YW-1:0]    cy,
  output logic [N_CH-1:0]       found,
  output logic                  res_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int NS  = 2 * N_CH;
  localparam int SW  = $clog2(NS);
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int KW  = $clog2(DIV_W + 1);
  localparam int SXW = XW + CW;
  localparam int SYW = YW + CW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t state;

  logic          vsync_q;
  logic          fe;
  logic          acc_en;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          full;
  logic [N_CH-1:0] hit;

  logic [SXW-1:0] sum_x  [N_CH];
  logic [SYW-1:0] sum_y  [N_CH];
  logic [CW-1:0]  cnt    [N_CH];
  logic [SXW-1:0] snap_x [N_CH];
  logic [SYW-1:0] snap_y [N_CH];
  logic [CW-1:0]  snap_n [N_CH];

  logic [SW-1:0]    slot;
  logic [KW-1:0]    step;
  logic [DIV_W-1:0] quo;
  logic [CW-1:0]    rem;

  logic [CHW-1:0]   ch_sel;
  logic [CW-1:0]    dvs;
  logic [DIV_W-1:0] dvd;
  logic [CW:0]      rs;
  logic [CW-1:0]    sub;
  logic             ge;
  logic [DIV_W-1:0] quo_nxt;
  logic [CW-1:0]    rem_nxt;
  logic             ok;
  logic             last_step;
  logic             last_slot;

  logic [XW-1:0]   stg_x [N_CH];
  logic [YW-1:0]   stg_y [N_CH];
  logic [N_CH-1:0] stg_f;
  logic [XW-1:0]   wx    [N_CH];
  logic [YW-1:0]   wy    [N_CH];
  logic [N_CH-1:0] wf;

  assign fe     = vsync & ~vsync_q;
  assign acc_en = pix_valid & ~vsync & ~full;
  assign busy   = (state != S_IDLE);

  // Per-channel masked colour compare
  always_comb begin
    hit = '0;
    for (int c = 0; c < N_CH; c++) begin
      hit[c] = ((pixel & match_mask[c*PIX_W +: PIX_W]) ==
                (match_val[c*PIX_W +: PIX_W] &
                 match_mask[c*PIX_W +: PIX_W]));
    end
  end

  // Raster position and per-channel sums for the current frame
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b1;
      x       <= '0;
      y       <= '0;
      full    <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        sum_x[c] <= '0;
        sum_y[c] <= '0;
        cnt[c]   <= '0;
      end
    end else begin
      vsync_q <= vsync;
      if (fe) begin
        x    <= '0;
        y    <= '0;
        full <= 1'b0;
        for (int c = 0; c < N_CH; c++) begin
          sum_x[c] <= '0;
          sum_y[c] <= '0;
          cnt[c]   <= '0;
        end
      end else if (acc_en) begin
        if (x == XW'(IMG_W - 1)) begin
          x <= '0;
          if (y == YW'(IMG_H - 1)) begin
            full <= 1'b1;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
        for (int c = 0; c < N_CH; c++) begin
          if (hit[c]) begin
            sum_x[c] <= sum_x[c] + SXW'(x);
            sum_y[c] <= sum_y[c] + SYW'(y);
            cnt[c]   <= cnt[c] + 1'b1;
          end
        end
      end
    end
  end

  // Operand select and one restoring-division step
  always_comb begin
    ch_sel = CHW'(slot >> 1);
    dvs    = snap_n[ch_sel];
    if (slot[0]) begin
      dvd = DIV_W'(snap_y[ch_sel]);
    end else begin
      dvd = DIV_W'(snap_x[ch_sel]);
    end
    rs  = {rem, quo[DIV_W-1]};
    ge  = (rs >= {1'b0, dvs});
    sub = rs[CW-1:0] - dvs;
    if (ge) begin
      rem_nxt = sub;
      quo_nxt = {quo[DIV_W-2:0], 1'b1};
    end else begin
      rem_nxt = rs[CW-1:0];
      quo_nxt = {quo[DIV_W-2:0], 1'b0};
    end
    ok        = (dvs >= CW'(MIN_PIX));
    last_step = (step == KW'(DIV_W));
    last_slot = (slot == SW'(NS - 1));
  end

  // Staged results with the finishing quotient merged in
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      wx[c] = stg_x[c];
      wy[c] = stg_y[c];
    end
    wf = stg_f;
    if (ok) begin
      if (slot[0]) begin
        wy[ch_sel] = quo_nxt[YW-1:0];
      end else begin
        wx[ch_sel] = quo_nxt[XW-1:0];
      end
      wf[ch_sel] = 1'b1;
    end
  end

  // Frame-end snapshot, divider sequencing and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      slot      <= '0;
      step      <= '0;
      quo       <= '0;
      rem       <= '0;
      stg_f     <= '0;
      cx        <= '0;
      cy        <= '0;
      found     <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        snap_x[c] <= '0;
        snap_y[c] <= '0;
        snap_n[c] <= '0;
        stg_x[c]  <= '0;
        stg_y[c]  <= '0;
      end
    end else begin
      res_valid <= 1'b0;
      if (fe && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (fe) begin
            for (int c = 0; c < N_CH; c++) begin
              snap_x[c] <= sum_x[c];
              snap_y[c] <= sum_y[c];
              snap_n[c] <= cnt[c];
            end
            stg_f <= '0;
            slot  <= '0;
            step  <= '0;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          if (step == '0) begin
            quo  <= dvd;
            rem  <= '0;
            step <= step + 1'b1;
          end else begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            if (last_step) begin
              step  <= '0;
              stg_x <= wx;
              stg_y <= wy;
              stg_f <= wf;
              if (last_slot) begin
                state     <= S_DONE;
                res_valid <= 1'b1;
                found     <= wf;
                for (int c = 0; c < N_CH; c++) begin
                  if (wf[c]) begin
                    cx[c*XW +: XW] <= wx[c];
                    cy[c*YW +: YW] <= wy[c];
                  end
                end
              end else begin
                slot <= slot + 1'b1;
              end
            end else begin
              step <= step + 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_marker_centroid_multi.sv
// tb_marker_centroid_multi: scoreboard bench for marker_centroid_multi
// on a reduced 64x48 raster so every frame fits in a short run.
module tb_marker_centroid_multi;

  localparam int W  = 64;
  localparam int H  = 48;
  localparam int PW = 12;
  localparam int NC = 2;
  localparam int MP = 4;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int CW = $clog2(W * H + 1);
  localparam int DW = ((XW > YW) ? XW : YW) + CW;
  localparam int L  = 2 * NC * (DW + 1) + 1;

  logic clk = 1'b0;
  logic rst;
  logic vsync;
  logic pix_valid;
  logic [PW-1:0]    pixel;
  logic [NC*PW-1:0] match_val;
  logic [NC*PW-1:0] match_mask;
  logic [NC*XW-1:0] cx;
  logic [NC*YW-1:0] cy;
  logic [NC-1:0]    found;
  logic res_valid;
  logic busy;
  logic overrun;

  marker_centroid_multi #(
    .IMG_W(W), .IMG_H(H), .PIX_W(PW), .N_CH(NC), .MIN_PIX(MP)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .pix_valid(pix_valid),
    .pixel(pixel), .match_val(match_val), .match_mask(match_mask),
    .cx(cx), .cy(cy), .found(found), .res_valid(res_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int               rise;
    logic [NC*XW-1:0] cx;
    logic [NC*YW-1:0] cy;
    logic [NC-1:0]    f;
  } exp_t;

  typedef struct {
    int          x;
    int          y;
    logic [PW-1:0] p;
  } hit_t;

  exp_t sb[$];
  hit_t hits[$];

  int     mx, my;
  bit     mfull;
  longint msx[NC];
  longint msy[NC];
  longint mcn[NC];
  logic [NC*XW-1:0] hold_cx;
  logic [NC*YW-1:0] hold_cy;

  function automatic bit ch_match(input int c, input logic [PW-1:0] p);
    logic [PW-1:0] v;
    logic [PW-1:0] m;
    v = match_val[c*PW +: PW];
    m = match_mask[c*PW +: PW];
    return ((p & m) == (v & m));
  endfunction

  function automatic logic [PW-1:0] pix_for(input int x, input int y);
    logic [PW-1:0] p;
    p = '0;
    foreach (hits[i]) begin
      if (hits[i].x == x && hits[i].y == y) p = hits[i].p;
    end
    return p;
  endfunction

  task automatic model_clear();
    mx = 0;
    my = 0;
    mfull = 0;
    for (int c = 0; c < NC; c++) begin
      msx[c] = 0;
      msy[c] = 0;
      mcn[c] = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    pix_valid = 0;
    pixel = 12'h00F;
    tick(n);
  endtask

  task automatic send_pix(input logic [PW-1:0] p);
    pix_valid = 1;
    pixel = p;
    if (!vsync && !mfull) begin
      for (int c = 0; c < NC; c++) begin
        if (ch_match(c, p)) begin
          msx[c] += mx;
          msy[c] += my;
          mcn[c]++;
        end
      end
      if (mx == W - 1) begin
        mx = 0;
        if (my == H - 1) mfull = 1;
        else my++;
      end else begin
        mx++;
      end
    end
    tick(1);
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 7 == 3) idle(1);
      send_pix(pix_for(mx, my));
    end
    pix_valid = 0;
  endtask

  task automatic end_frame(input bit want, input int blank);
    exp_t e;
    vsync = 1;
    pix_valid = 1;
    pixel = 12'h00F;
    if (want) begin
      e.rise = cyc;
      e.cx = hold_cx;
      e.cy = hold_cy;
      e.f = '0;
      for (int c = 0; c < NC; c++) begin
        if (mcn[c] >= MP) begin
          e.cx[c*XW +: XW] = XW'(msx[c] / mcn[c]);
          e.cy[c*YW +: YW] = YW'(msy[c] / mcn[c]);
          e.f[c] = 1'b1;
        end
      end
      hold_cx = e.cx;
      hold_cy = e.cy;
      sb.push_back(e);
    end
    model_clear();
    tick(blank);
    vsync = 0;
    pix_valid = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < L + 20 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    if (sb.size() != 0) begin
      check("result_timeout", sb.size(), 0);
      sb.delete();
    end
    tick(1);
  endtask

  task automatic do_reset();
    rst = 1;
    vsync = 1;
    pix_valid = 0;
    pixel = '0;
    tick(3);
    rst = 0;
    model_clear();
    hold_cx = '0;
    hold_cy = '0;
    sb.delete();
  endtask

  task automatic add_hit(input int x, input int y, input logic [PW-1:0] p);
    hit_t h;
    h.x = x;
    h.y = y;
    h.p = p;
    hits.push_back(h);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid) begin
      if (sb.size() == 0) begin
        check("spurious_res_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("latency", cyc - e.rise, L);
        check("cx", cx, e.cx);
        check("cy", cy, e.cy);
        check("found", found, e.f);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    match_val  = {12'hF00, 12'h00F};
    match_mask = {12'hF00, 12'hFFF};
    do_reset();

    check("rst_cx", cx, 0);
    check("rst_cy", cy, 0);
    check("rst_found", found, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    tick(2);
    check("no_edge_after_rst", busy, 0);
    vsync = 0;
    tick(2);

    // square blob, exactly MP pixels
    hits.delete();
    add_hit(40, 30, 12'h00F);
    add_hit(41, 30, 12'h00F);
    add_hit(40, 31, 12'h00F);
    add_hit(41, 31, 12'h00F);
    stream(W * H);
    end_frame(1, 4);
    check("busy_in_div", busy, 1);
    check("no_overrun", overrun, 0);
    wait_done();

    // ch0 single pixel (low count), ch1 five masked pixels
    hits.delete();
    add_hit(10, 20, 12'h00F);
    add_hit(11, 20, 12'h00E);
    add_hit(50, 40, 12'hF12);
    add_hit(51, 40, 12'hF34);
    add_hit(52, 40, 12'hFFF);
    add_hit(53, 40, 12'hF00);
    add_hit(54, 40, 12'hF0A);
    add_hit(55, 40, 12'hE00);
    stream(W * H);
    end_frame(1, 4);
    wait_done();

    // empty frame
    hits.delete();
    stream(W * H);
    end_frame(1, 4);
    wait_done();

    // second frame end while dividing
    hits.delete();
    add_hit(5, 5, 12'h00F);
    add_hit(6, 5, 12'h00F);
    add_hit(5, 6, 12'h00F);
    add_hit(6, 6, 12'h00F);
    stream(W * H);
    end_frame(1, 5);
    stream(40);
    end_frame(0, 5);
    check("overrun_set", overrun, 1);
    wait_done();
    idle(L + 10);
    check("overrun_sticky", overrun, 1);

    // reset in the middle of a division
    hits.delete();
    add_hit(30, 10, 12'h00F);
    add_hit(31, 10, 12'h00F);
    add_hit(30, 11, 12'h00F);
    add_hit(31, 11, 12'h00F);
    stream(W * H);
    end_frame(0, 4);
    tick(36);
    check("busy_before_rst", busy, 1);
    do_reset();
    check("mid_rst_cx", cx, 0);
    check("mid_rst_cy", cy, 0);
    check("mid_rst_found", found, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun, 0);
    vsync = 0;
    idle(L + 10);
    hits.delete();
    add_hit(20, 10, 12'hF55);
    add_hit(21, 10, 12'hF55);
    add_hit(22, 10, 12'hF55);
    add_hit(23, 10, 12'hF55);
    stream(W * H);
    end_frame(1, 4);
    wait_done();

    // full raster, extras after the last pixel, ch1 one short of MP
    hits.delete();
    add_hit(1, 1, 12'hF00);
    add_hit(2, 1, 12'hF00);
    add_hit(3, 1, 12'hF00);
    add_hit(60, H - 1, 12'h00F);
    add_hit(61, H - 1, 12'h00F);
    add_hit(62, H - 1, 12'h00F);
    add_hit(63, H - 1, 12'h00F);
    stream(W * H);
    for (int i = 0; i < 10; i++) send_pix(12'h00F);
    end_frame(1, 4);
    wait_done();
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
